elastic_memory_responder: RTL and testbench
===========================================

ELASTIC_MEMORY_RESPONDER -- requirements
Module: elastic_memory_responder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default DATA_WIDTH from param.v, word width; ADDRESS_WIDTH, default ADDRESS_WIDTH from param.v, address width; MEM_DEPTH, default 256, number of words; READ_CYCLE, default LOAD_CYCLE from param.v, read latency in cycles (>=1).
REQ-002 Clocking SHALL be one clock, clk, rising edge; reset SHALL be a single port named reset, synchronous, active-high.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- start_exec  in  1  execution start pulse
- init_write  in  1  preload write strobe, honoured only before execution starts
- init_address  in  ADDRESS_WIDTH  preload address
- init_data  in  DATA_WIDTH  preload data
- req_valid  in  1  SELF request valid
- req_stop  out  1  SELF request stop
- req_write  in  1  1 = write, 0 = read
- req_address  in  ADDRESS_WIDTH  request address
- req_write_data  in  DATA_WIDTH  write data
- resp_valid  out  1  SELF response valid
- resp_stop  in  1  SELF response stop
- resp_data  out  DATA_WIDTH  read data

Function
REQ-004 A request transfer SHALL occur on a cycle with req_valid & !req_stop; a response transfer SHALL occur on a cycle with resp_valid & !resp_stop.
REQ-005 Execution SHALL be enabled from the cycle after start_exec is sampled high and SHALL stay enabled until reset; before that, req_stop SHALL be 1 and no request SHALL be accepted.
REQ-006 init_write SHALL write init_data to init_address at the clock edge only while execution is not enabled; once enabled, it SHALL be ignored.
REQ-007 The FSM SHALL have states IDLE, READ_WAIT, RESPOND; req_stop SHALL be 0 only in IDLE with execution enabled; resp_valid SHALL be 1 only in RESPOND.
REQ-008 In IDLE, an accepted write SHALL commit req_write_data to req_address at that edge; the FSM SHALL stay in IDLE; no response SHALL be produced.
REQ-009 In IDLE, an accepted read SHALL sample mem[req_address] at that edge; if READ_CYCLE==1 the next state SHALL be RESPOND, else READ_WAIT with counter loaded with READ_CYCLE-1.
REQ-010 In READ_WAIT, the counter SHALL decrement each cycle; the transition to RESPOND SHALL happen on the edge where the counter equals 1; first resp_valid cycle is READ_CYCLE cycles after the accept cycle.
REQ-011 In RESPOND, resp_data SHALL hold the sampled word stable while resp_stop is 1; on a response transfer the next state SHALL be IDLE.
REQ-012 A write committed at edge N SHALL be visible to a read accepted at edge N+1 or later.
REQ-013 Addresses >= MEM_DEPTH SHALL be out of range: writes ignored, reads return 0 with normal latency and handshake.
REQ-014 Address arithmetic SHALL use only the low ADDRESS_WIDTH bits; no wrap-around into valid range SHALL occur.
REQ-015 Sustained throughput SHALL be one write per cycle and one read per READ_CYCLE+1 cycles under resp_stop=0.

Reset
REQ-016 On reset: state IDLE, execution disabled, counter 0, req_stop 1, resp_valid 0, resp_data 0.
REQ-017 Reset asserted mid-read SHALL abandon the pending read without producing a response; memory contents SHALL NOT be cleared by reset.

Structure
REQ-018 DATA_WIDTH, ADDRESS_WIDTH and LOAD_CYCLE SHALL come from the shared param.v; FSM state encodings SHALL be local to this module.
REQ-019 The storage SHALL be one sub-module, memory_array: one write port (muxed between init and request), one combinational read port.

Verification
REQ-020 Preload mem[5]=0x1234 via init_write, pulse start_exec, read addr 5, READ_CYCLE=3, resp_stop=0 -> resp_valid high exactly 3 cycles after accept, resp_data=0x1234, req_stop back to 0 next cycle.
REQ-021 Write 0xABCD to addr 10 at edge N, read addr 10 accepted at edge N+1 -> resp_data=0xABCD.
REQ-022 Read addr 7 (value 0x55), hold resp_stop=1 for 4 cycles -> resp_valid and resp_data=0x55 stable 4 cycles, req_stop=1 throughout, single transfer when resp_stop drops.
REQ-023 MEM_DEPTH=256, write 0x99 to addr 300 then read addr 300 and addr 44 -> both responses 0 (addr 44 unwritten-after-zero-preload), mem[44] unchanged.
REQ-024 Accept read, assert reset during READ_WAIT -> no resp_valid ever for that read; req_stop=1 until start_exec re-pulsed; preloaded data still readable.
REQ-025 init_write to addr 3 after execution enabled -> mem[3] unchanged on subsequent read.

Source files
------------

// File: rtl/elastic_memory_responder_pkg.sv
// Shared word/address widths and default read latency used by the memory responder and its storage.
package elastic_memory_responder_pkg;
  localparam int DATA_WIDTH        = 16;
  localparam int ADDRESS_WIDTH     = 10;
  localparam int LOAD_CYCLE        = 3;
  localparam int DEFAULT_MEM_DEPTH = 256;
endpackage

// File: rtl/elastic_memory_responder_memory_array.sv
// Word storage with one write port and one combinational read port.
// Addresses at or above MEM_DEPTH are inert: writes are dropped and reads return zero.
module memory_array
  import elastic_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH    = elastic_memory_responder_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = elastic_memory_responder_pkg::ADDRESS_WIDTH,
  parameter int MEM_DEPTH     = DEFAULT_MEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [ADDRESS_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L = (ADDRESS_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // Range is checked on the full address so high bits never alias into the array.
  assign w_wr_ok = ({1'b0, i_waddr} < DEPTH_L);
  assign w_rd_ok = ({1'b0, i_raddr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (i_we && w_wr_ok) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_ok ? r_mem[i_raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/elastic_memory_responder.sv
// Valid/stop memory responder: writes commit on accept; reads respond READ_CYCLE cycles after accept.
// req_stop holds off new requests until the pending response transfers; resp_data holds under resp_stop.
module elastic_memory_responder
  import elastic_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH    = elastic_memory_responder_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = elastic_memory_responder_pkg::ADDRESS_WIDTH,
  parameter int MEM_DEPTH     = DEFAULT_MEM_DEPTH,
  parameter int READ_CYCLE    = elastic_memory_responder_pkg::LOAD_CYCLE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_exec,
  input  logic                     init_write,
  input  logic [ADDRESS_WIDTH-1:0] init_address,
  input  logic [DATA_WIDTH-1:0]    init_data,
  input  logic                     req_valid,
  output logic                     req_stop,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_write_data,
  output logic                     resp_valid,
  input  logic                     resp_stop,
  output logic [DATA_WIDTH-1:0]    resp_data
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_RESPOND   = 2'd2
  } state_t;

  localparam int CNT_W = (READ_CYCLE > 1) ? $clog2(READ_CYCLE) : 1;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_exec_en;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_req_stop;
  logic                    w_resp_valid;
  logic                    w_req_fire;
  logic                    w_resp_fire;
  logic                    w_rd_fire;
  logic                    w_wr_fire;
  logic                    w_init_we;
  logic                    w_mem_we;
  logic [ADDRESS_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic [DATA_WIDTH-1:0]   w_mem_rdata;

  assign w_req_fire  = req_valid & ~w_req_stop;
  assign w_resp_fire = w_resp_valid & ~resp_stop;
  assign w_rd_fire   = w_req_fire & ~req_write;
  assign w_wr_fire   = w_req_fire & req_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec_en <= 1'b0;
    end else if (start_exec) begin
      r_exec_en <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_fire) begin
          w_next_state = (READ_CYCLE == 1) ? ST_RESPOND : ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (w_resp_fire) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_req_stop   = 1'b1;
    w_resp_valid = 1'b0;
    case (r_state)
      ST_IDLE:    w_req_stop   = ~r_exec_en;
      ST_RESPOND: w_resp_valid = 1'b1;
      default: begin
        w_req_stop   = 1'b1;
        w_resp_valid = 1'b0;
      end
    endcase
  end

  // Read word is captured at accept so later writes cannot disturb the pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rdata <= '0;
    end else if (w_rd_fire) begin
      r_cnt   <= CNT_W'(READ_CYCLE - 1);
      r_rdata <= w_mem_rdata;
    end else if (r_state == ST_READ_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Preload and request writes never overlap: requests are only accepted once execution is enabled.
  assign w_init_we   = init_write & ~r_exec_en;
  assign w_mem_we    = w_init_we | w_wr_fire;
  assign w_mem_waddr = w_init_we ? init_address : req_address;
  assign w_mem_wdata = w_init_we ? init_data : req_write_data;

  memory_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .MEM_DEPTH     (MEM_DEPTH)
  ) u_memory_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (req_address),
    .o_rdata (w_mem_rdata)
  );

  assign req_stop   = w_req_stop;
  assign resp_valid = w_resp_valid;
  assign resp_data  = r_rdata;

endmodule

// File: tb/tb_elastic_memory_responder.sv
// Directed plus randomized bench for elastic_memory_responder against an array-based memory model.
module tb_elastic_memory_responder;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 256;
  localparam int RC    = 3;

  logic          clk;
  logic          reset;
  logic          start_exec;
  logic          init_write;
  logic [AW-1:0] init_address;
  logic [DW-1:0] init_data;
  logic          req_valid;
  logic          req_stop;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_write_data;
  logic          resp_valid;
  logic          resp_stop;
  logic [DW-1:0] resp_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_exec;

  elastic_memory_responder #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .MEM_DEPTH     (DEPTH),
    .READ_CYCLE    (RC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_exec     (start_exec),
    .init_write     (init_write),
    .init_address   (init_address),
    .init_data      (init_data),
    .req_valid      (req_valid),
    .req_stop       (req_stop),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .resp_valid     (resp_valid),
    .resp_stop      (resp_stop),
    .resp_data      (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int addr);
    return (addr < DEPTH) ? model_mem[addr] : '0;
  endfunction

  task automatic preload(input int addr, input logic [DW-1:0] data);
    init_address = AW'(addr);
    init_data    = data;
    init_write   = 1'b1;
    tick();
    init_write   = 1'b0;
    if (!model_exec && addr < DEPTH) model_mem[addr] = data;
  endtask

  task automatic start();
    start_exec = 1'b1;
    tick();
    start_exec = 1'b0;
    model_exec = 1'b1;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    chk("wr_req_stop", 32'(req_stop), 32'd0);
    req_valid      = 1'b1;
    req_write      = 1'b1;
    req_address    = AW'(addr);
    req_write_data = data;
    tick();
    req_valid = 1'b0;
    if (addr < DEPTH) model_mem[addr] = data;
  endtask

  // Read with resp_stop held high for 'stall' cycles of resp_valid before the transfer.
  task automatic rd(input int addr, input int stall);
    logic [DW-1:0] exp;
    int n;
    exp = model_read(addr);
    chk("rd_req_stop", 32'(req_stop), 32'd0);
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = AW'(addr);
    resp_stop   = (stall > 0);
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 4 * RC + 8) begin
      tick();
      n++;
    end
    chk("rd_latency", 32'(n), 32'(RC));
    if (resp_valid) begin
      chk("rd_data", 32'(resp_data), 32'(exp));
      for (int i = 0; i < stall; i++) begin
        chk("stall_valid", 32'(resp_valid), 32'd1);
        chk("stall_data", 32'(resp_data), 32'(exp));
        chk("stall_req_stop", 32'(req_stop), 32'd1);
        tick();
      end
      resp_stop = 1'b0;
      chk("xfer_valid", 32'(resp_valid), 32'd1);
      tick();
      chk("post_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_req_stop", 32'(req_stop), 32'd0);
    end
    resp_stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_exec = 1'b0; init_write = 1'b0;
    init_address = '0; init_data = '0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_write_data = '0;
    resp_stop = 1'b0;
    model_exec = 1'b0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;

    tick();
    tick();
    chk("rst_req_stop", 32'(req_stop), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    reset = 1'b0;
    tick();
    chk("pre_exec_req_stop", 32'(req_stop), 32'd1);

    // Fill memory with random words, then pin the directed locations.
    for (int a = 0; a < DEPTH; a++) preload(a, DW'($urandom));
    preload(5, 16'h1234);
    preload(7, 16'h0055);
    preload(44, 16'h0000);
    preload(3, 16'h0333);

    // Requests before start must be refused and must not write.
    req_valid = 1'b1; req_write = 1'b1; req_address = AW'(5); req_write_data = 16'hBEEF;
    tick();
    chk("pre_exec_refuse", 32'(req_stop), 32'd1);
    tick();
    req_valid = 1'b0;

    start();
    chk("exec_req_stop", 32'(req_stop), 32'd0);
    rd(5, 0);

    wr(10, 16'hABCD);
    rd(10, 0);

    rd(7, 4);

    wr(300, 16'h0099);
    rd(300, 0);
    rd(44, 0);

    // Execution-time preload must be ignored.
    preload(3, 16'hDEAD);
    rd(3, 0);

    // Reset while the read is waiting must drop the response.
    req_valid = 1'b1; req_write = 1'b0; req_address = AW'(5);
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_exec = 1'b0;
    chk("midrd_rst_data", 32'(resp_data), 32'd0);
    for (int i = 0; i < 2 * RC + 4; i++) begin
      chk("midrd_no_resp", 32'(resp_valid), 32'd0);
      chk("midrd_req_stop", 32'(req_stop), 32'd1);
      tick();
    end
    start();
    rd(5, 0);
    rd(7, 1);

    // Back-to-back writes, one per cycle, then readback.
    wr(20, 16'h1111);
    wr(21, 16'h2222);
    wr(22, 16'h3333);
    rd(21, 0);
    rd(20, 2);

    for (int k = 0; k < 60; k++) begin
      int op;
      int addr;
      op   = int'($urandom_range(0, 2));
      addr = int'($urandom_range(0, 299));
      if (op == 0) begin
        wr(addr, DW'($urandom));
      end else if (op == 1) begin
        rd(addr, int'($urandom_range(0, 2)));
      end else begin
        wr(addr, DW'($urandom));
        rd(addr, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
